// File: rtl/banked_memory_model.sv
// Banked external-memory model: NUM_CH requesters, word-interleaved banks,
// per-bank round-robin arbitration, byte-enable writes and fixed-latency
// read responses with an out-of-range error flag.
module banked_memory_model #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_SIZE_WORDS = 1024,
    parameter int LATENCY        = 3,
    parameter int NUM_CH         = 2,
    parameter int NUM_BANKS      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              req_valid_i,
    output logic [NUM_CH-1:0]              req_ready_o,
    input  logic [NUM_CH-1:0]              req_we_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] req_be_i,
    output logic [NUM_CH-1:0]              resp_valid_o,
    output logic [NUM_CH*DATA_WIDTH-1:0]   resp_rdata_o,
    output logic [NUM_CH-1:0]              resp_err_o
);

    localparam int BE_W       = DATA_WIDTH / 8;
    localparam int BANK_SHIFT = $clog2(NUM_BANKS);
    localparam int BANK_W     = (NUM_BANKS > 1) ? BANK_SHIFT : 1;
    localparam int ROWS       = MEM_SIZE_WORDS / NUM_BANKS;
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE_WORDS);

    // Parameter legality, caught at elaboration
    if (LATENCY < 1) begin : g_chk_latency
        $error("banked_memory_model: LATENCY must be >= 1");
    end
    if (NUM_CH < 1) begin : g_chk_num_ch
        $error("banked_memory_model: NUM_CH must be >= 1");
    end
    if ((NUM_BANKS < 1) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_chk_banks
        $error("banked_memory_model: NUM_BANKS must be a power of two");
    end
    if ((MEM_SIZE_WORDS % NUM_BANKS) != 0) begin : g_chk_size
        $error("banked_memory_model: MEM_SIZE_WORDS must be a multiple of NUM_BANKS");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_chk_width
        $error("banked_memory_model: DATA_WIDTH must be a multiple of 8");
    end

    // Low address bits select the bank; a single bank always decodes to 0.
    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_WIDTH-1:0] addr);
        if (NUM_BANKS > 1) begin
            return BANK_W'(addr);
        end
        return '0;
    endfunction

    // Remaining address bits select the row inside the bank.
    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_WIDTH-1:0] addr);
        return ROW_W'(addr >> BANK_SHIFT);
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < MEM_LIMIT);
    endfunction

    // Distance of channel c from the bank pointer, walking upward mod NUM_CH.
    function automatic int rr_dist(input logic [CH_W-1:0] ptr, input int c);
        int d;
        d = c - int'(ptr);
        if (d < 0) begin
            d = d + NUM_CH;
        end
        return d;
    endfunction

    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][ROWS];

    logic [BANK_W-1:0]     ch_bank     [NUM_CH];
    logic [ROW_W-1:0]      ch_row      [NUM_CH];
    logic                  ch_in_range [NUM_CH];

    logic [CH_W-1:0]       rr_ptr   [NUM_BANKS];
    logic [CH_W-1:0]       rr_nxt   [NUM_BANKS];
    logic [CH_W-1:0]       bank_win [NUM_BANKS];
    logic                  bank_hit [NUM_BANKS];
    logic [NUM_CH-1:0]     gnt;

    logic                  vld_p   [NUM_CH][LATENCY];
    logic [DATA_WIDTH-1:0] rdata_p [NUM_CH][LATENCY];
    logic                  err_p   [NUM_CH][LATENCY];

    // Per-channel address decode into bank, row and range check
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_bank[c]     = bank_of(req_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]);
            ch_row[c]      = row_of(req_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]);
            ch_in_range[c] = in_range(req_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    // Per-bank round-robin: the first valid channel at or after the pointer wins
    always_comb begin
        gnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_hit[b] = 1'b0;
            bank_win[b] = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (!bank_hit[b] && req_valid_i[c] && (int'(ch_bank[c]) == b) &&
                        (rr_dist(rr_ptr[b], c) == k)) begin
                        bank_hit[b] = 1'b1;
                        bank_win[b] = CH_W'(c);
                        gnt[c]      = 1'b1;
                    end
                end
            end
            rr_nxt[b] = (int'(bank_win[b]) == NUM_CH - 1) ? '0 : bank_win[b] + CH_W'(1);
        end
    end

    assign req_ready_o = gnt;

    // Arbitration pointers and read-valid pipeline; reset drops in-flight reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr[b] <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < LATENCY; s++) begin
                    vld_p[c][s] <= 1'b0;
                end
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bank_hit[b]) begin
                    rr_ptr[b] <= rr_nxt[b];
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                // stage p0: read accepted at this edge
                vld_p[c][0] <= gnt[c] && !req_we_i[c];
                // stages p1..: fixed-latency delay line
                for (int s = 1; s < LATENCY; s++) begin
                    vld_p[c][s] <= vld_p[c][s-1];
                end
            end
        end
    end

    // Read data and error flag delay line; outputs are gated by valid so no reset
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            // stage p0: sample the array before this edge's write lands
            rdata_p[c][0] <= ch_in_range[c] ? mem[ch_bank[c]][ch_row[c]] : '0;
            err_p[c][0]   <= !ch_in_range[c];
            // stages p1..: follow the valid pipeline
            for (int s = 1; s < LATENCY; s++) begin
                rdata_p[c][s] <= rdata_p[c][s-1];
                err_p[c][s]   <= err_p[c][s-1];
            end
        end
    end

    // Byte-masked writes; out-of-range writes are accepted but dropped
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt[c] && req_we_i[c] && ch_in_range[c]) begin
                for (int j = 0; j < BE_W; j++) begin
                    if (req_be_i[c*BE_W + j]) begin
                        mem[ch_bank[c]][ch_row[c]][j*8 +: 8] <= req_wdata_i[c*DATA_WIDTH + j*8 +: 8];
                    end
                end
            end
        end
    end

    // Response outputs: data and error are zero outside the valid pulse
    always_comb begin
        resp_valid_o = '0;
        resp_rdata_o = '0;
        resp_err_o   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            resp_valid_o[c] = vld_p[c][LATENCY-1];
            if (vld_p[c][LATENCY-1]) begin
                resp_rdata_o[c*DATA_WIDTH +: DATA_WIDTH] = rdata_p[c][LATENCY-1];
                resp_err_o[c]                            = err_p[c][LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_banked_memory_model.sv
// Scoreboard bench for banked_memory_model: directed requests push expected
// read responses per channel; a negedge monitor pops and compares them.
module tb_banked_memory_model;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int MEM = 64;
    localparam int LAT = 3;
    localparam int NCH = 2;
    localparam int NB  = 4;
    localparam int BW  = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [NCH-1:0]    req_valid, req_ready, req_we, resp_valid, resp_err;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata, resp_rdata;
    logic [NCH*BW-1:0] req_be;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } exp_t;

    exp_t sbq [NCH][$];
    exp_t mon_e;

    banked_memory_model #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE_WORDS(MEM),
        .LATENCY(LAT), .NUM_CH(NCH), .NUM_BANKS(NB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the head of its channel's queue
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (resp_valid[c]) begin
                if (sbq[c].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp ch%0d: got valid expected none (cycle %0d)", c, cyc);
                end else begin
                    mon_e = sbq[c].pop_front();
                    chk("resp_rdata", 64'(resp_rdata[c*DW +: DW]), 64'(mon_e.data));
                    chk("resp_err", 64'(resp_err[c]), 64'(mon_e.err));
                    chk("resp_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end else begin
                chk("idle_rdata_zero", 64'(resp_rdata[c*DW +: DW]), 64'd0);
                chk("idle_err_zero", 64'(resp_err[c]), 64'd0);
            end
        end
    end

    // Present requests on the masked channels and hold each until accepted
    task automatic issue(input logic [NCH-1:0] v, input logic [NCH-1:0] we,
                         input logic [NCH*AW-1:0] addr, input logic [NCH*DW-1:0] wd,
                         input logic [NCH*BW-1:0] be, input logic [NCH*DW-1:0] ed,
                         input logic [NCH-1:0] ee, input bit push,
                         output int acc0, output int acc1);
        logic [NCH-1:0] pend;
        int acc [NCH];
        exp_t e;
        pend = v;
        acc[0] = -1;
        acc[1] = -1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        req_valid = pend;
        for (int n = 0; n < 20 && pend != '0; n++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (pend[c] && req_ready[c]) begin
                    acc[c] = cyc;
                    pend[c] = 1'b0;
                    if (!we[c] && push) begin
                        e.data = ed[c*DW +: DW];
                        e.err  = ee[c];
                        e.due  = cyc + LAT;
                        sbq[c].push_back(e);
                    end
                end
            end
            @(posedge clk);
            #1;
            req_valid = pend;
        end
        if (pend != '0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got pending %b expected 00", pend);
        end
        req_valid = '0;
        acc0 = acc[0];
        acc1 = acc[1];
    endtask

    task automatic wr1(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be, output int acc);
        int a0, a1;
        issue(NCH'(1 << ch), NCH'(1 << ch), (NCH*AW)'(a) << (ch*AW), (NCH*DW)'(d) << (ch*DW),
              (NCH*BW)'(be) << (ch*BW), '0, '0, 1'b1, a0, a1);
        acc = (ch == 0) ? a0 : a1;
    endtask

    task automatic rd1(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] ed,
                       input logic ee, input bit push, output int acc);
        int a0, a1;
        issue(NCH'(1 << ch), '0, (NCH*AW)'(a) << (ch*AW), '0, '0,
              (NCH*DW)'(ed) << (ch*DW), NCH'(ee) << ch, push, a0, a1);
        acc = (ch == 0) ? a0 : a1;
    endtask

    initial begin
        int t0, t1, tw, tr, ta, tb, tc;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_ready_idle", 64'(req_ready), 64'd0);
        chk("reset_rdata", 64'(resp_rdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Seed bank 0 through ch1 so its pointer returns to 0
        wr1(1, 16'd4, 32'h4444_4444, 4'hF, tw);
        wr1(1, 16'd8, 32'h8888_8888, 4'hF, tw);

        // Conflict on bank 0 with pointer 0: ch0 first, then ch1
        issue(2'b11, 2'b00, {16'd8, 16'd4}, '0, '0, {32'h8888_8888, 32'h4444_4444}, 2'b00, 1'b1, t0, t1);
        chk("conflict_ptr0_order", 64'(t1 - t0), 64'd1);

        // ch0 alone moves the pointer to 1, so ch1 wins the next conflict
        rd1(0, 16'd4, 32'h4444_4444, 1'b0, 1'b1, ta);
        issue(2'b11, 2'b00, {16'd8, 16'd4}, '0, '0, {32'h8888_8888, 32'h4444_4444}, 2'b00, 1'b1, t0, t1);
        chk("conflict_ptr1_order", 64'(t0 - t1), 64'd1);

        // Write then read in the next cycle
        wr1(0, 16'd5, 32'hDEAD_BEEF, 4'hF, tw);
        rd1(0, 16'd5, 32'hDEAD_BEEF, 1'b0, 1'b1, tr);
        chk("rd_after_wr_next_cycle", 64'(tr - tw), 64'd1);

        // Byte-enable merge
        wr1(0, 16'd8, 32'h1122_3344, 4'hF, tw);
        wr1(0, 16'd8, 32'hAABB_CCDD, 4'b0101, tw);
        rd1(0, 16'd8, 32'h11BB_33DD, 1'b0, 1'b1, tr);

        // Different banks are served in the same cycle
        issue(2'b11, 2'b11, {16'd2, 16'd1}, {32'h0202_0202, 32'h0101_0101}, 8'hFF, '0, 2'b00, 1'b1, t0, t1);
        chk("no_conflict_wr_same_cycle", 64'(t1 - t0), 64'd0);
        issue(2'b11, 2'b00, {16'd2, 16'd1}, '0, '0, {32'h0202_0202, 32'h0101_0101}, 2'b00, 1'b1, t0, t1);
        chk("no_conflict_rd_same_cycle", 64'(t1 - t0), 64'd0);

        // Out of range: write dropped (would alias row 0 of bank 0), read flags err
        wr1(0, 16'd0, 32'h00C0_FFEE, 4'hF, tw);
        wr1(0, 16'(MEM), 32'hBAD0_BAD0, 4'hF, tw);
        rd1(0, 16'(MEM), 32'h0, 1'b1, 1'b1, tr);
        rd1(0, 16'd0, 32'h00C0_FFEE, 1'b0, 1'b1, tr);

        // Back-to-back reads give back-to-back responses
        rd1(0, 16'd5, 32'hDEAD_BEEF, 1'b0, 1'b1, ta);
        rd1(0, 16'd8, 32'h11BB_33DD, 1'b0, 1'b1, tb);
        rd1(0, 16'd1, 32'h0101_0101, 1'b0, 1'b1, tc);
        chk("b2b_accept_gap", 64'((tb - ta) + (tc - tb)), 64'd2);
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Reset mid-flight: bank 0 pointer is 1 before reset, these reads never respond
        rd1(0, 16'd4, 32'h0, 1'b0, 1'b0, ta);
        rd1(0, 16'd8, 32'h0, 1'b0, 1'b0, tb);
        rd1(0, 16'd0, 32'h0, 1'b0, 1'b0, tc);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid_now", 64'(resp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_valid_held", 64'(resp_valid), 64'd0);
        chk("midreset_rdata", 64'(resp_rdata), 64'd0);
        chk("midreset_err", 64'(resp_err), 64'd0);
        rst_n = 1'b1;
        repeat (LAT + 5) @(posedge clk);
        #1;

        // Pointer back to 0: ch0 wins first, responses normal
        issue(2'b11, 2'b00, {16'd8, 16'd4}, '0, '0, {32'h11BB_33DD, 32'h4444_4444}, 2'b00, 1'b1, t0, t1);
        chk("post_reset_ptr0_order", 64'(t1 - t0), 64'd1);

        for (int i = 0; i < 50 && (sbq[0].size() != 0 || sbq[1].size() != 0); i++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            chk("scoreboard_drained", 64'(sbq[c].size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banked_memory_model.md
Name: banked_memory_model

Overview:
- Multi-channel, multi-bank behavioural model of external memory (HBM/DDR class) for the NMCU.
- Serves NUM_CH independent requesters with valid/ready request handshake, byte-enable writes and per-channel fixed-latency read responses.
- Addresses are word-interleaved across NUM_BANKS banks; each bank serves one access per cycle, with round-robin arbitration on conflicts.
- Out-of-range accesses are flagged with an error response.
- Sits between NMCU load/store engines and the top-level testbench, replacing the single-port, always-accepting memory model.

Parameters:
- DATA_WIDTH, nmcu_pkg::DATA_WIDTH, word width in bits; multiple of 8.
- ADDR_WIDTH, nmcu_pkg::ADDR_WIDTH, word address width.
- MEM_SIZE_WORDS, nmcu_pkg::MEM_SIZE_WORDS, total words; multiple of NUM_BANKS.
- LATENCY, nmcu_pkg::MEM_LATENCY, grant-to-read-response cycles; must be >= 1.
- NUM_CH, 2, number of requester channels; must be >= 1.
- NUM_BANKS, 4, bank count; power of two, >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_CH  per-channel request valid.
- req_ready_o  out  NUM_CH  per-channel request accepted this cycle.
- req_we_i  in  NUM_CH  1 = write, 0 = read.
- req_addr_i  in  NUM_CH*ADDR_WIDTH  word address; channel c at slice c.
- req_wdata_i  in  NUM_CH*DATA_WIDTH  write data.
- req_be_i  in  NUM_CH*(DATA_WIDTH/8)  write byte enables.
- resp_valid_o  out  NUM_CH  read response valid; one-cycle pulse per read.
- resp_rdata_o  out  NUM_CH*DATA_WIDTH  read data.
- resp_err_o  out  NUM_CH  read was out of range.

Behaviour:
- Bank mapping: bank = addr mod NUM_BANKS (low log2 bits); row = addr / NUM_BANKS. NUM_BANKS = 1 means a single bank, row = addr.
- Handshake: a request is accepted in a cycle where req_valid_i[c] && req_ready_o[c].
- req_ready_o[c] is combinational and is 1 iff channel c is valid and wins arbitration for its target bank this cycle. Requesters hold valid, address and data stable until accepted.
- Arbitration: one round-robin pointer per bank, reset to 0. Among valid channels targeting that bank, the grant goes to the first channel at or after the pointer (mod NUM_CH). On a grant, pointer <= granted + 1 mod NUM_CH; with no grant the pointer is unchanged.
- Channels targeting different banks are all granted in the same cycle.
- Writes: on acceptance, bytes with be = 1 are updated at the clock edge and other bytes are kept. be = 0 is a legal no-op. Writes produce no response.
- Reads: data is sampled from the array at the acceptance edge, so a write accepted in cycle t is visible to a read accepted in t+1 or later.
- Read response: resp_valid_o[c] is high exactly in cycle t+LATENCY for a read accepted in cycle t, together with rdata and err.
- Responses per channel return in acceptance order; there is no response backpressure. Back-to-back reads give back-to-back responses.
- Outside response cycles, resp_rdata_o and resp_err_o hold 0.
- Out of range (addr >= MEM_SIZE_WORDS): the request is still arbitrated and accepted and consumes the bank slot.
  - Write: discarded, array unchanged.
  - Read: responds with rdata = 0, err = 1.
- Reset (asynchronous, any time):
  - Outputs: resp_valid_o = 0, resp_rdata_o = 0, resp_err_o = 0. req_ready_o follows arbitration combinationally.
  - State: all latency-pipe valids cleared, so in-flight reads are dropped and never respond after reset release. Arbitration pointers = 0.
  - Array contents are not reset.
- Reads of never-written locations return X in simulation. No checks beyond the parameter legality assertions at elaboration: LATENCY >= 1; NUM_BANKS a power of two; MEM_SIZE_WORDS mod NUM_BANKS == 0; DATA_WIDTH mod 8 == 0.

Test Plan:
- Single channel, LATENCY = 3: write 0xDEADBEEF to addr 5 (be all 1), then read addr 5 in the next cycle -> resp_valid_o[0] high exactly 3 cycles after the read acceptance, rdata = 0xDEADBEEF, err = 0.
- Byte enables: write 0x11223344 to addr 8, then write 0xAABBCCDD with be = 4'b0101 -> read returns 0x11BB33DD.
- Bank conflict, NUM_CH = 2, NUM_BANKS = 4: both channels read addrs 4 and 8 (both bank 0) for two consecutive cycles -> ch0 granted first (pointer 0), then ch1; req_ready_o one-hot each cycle. Responses land LATENCY cycles after each grant.
- No conflict: ch0 reads addr 1 and ch1 reads addr 2 in the same cycle -> both ready = 1, both responses in the same cycle, LATENCY cycles later.
- Out of range: read addr MEM_SIZE_WORDS -> rdata = 0, err = 1. A write to the same address leaves a known in-range location unchanged.
- Reset mid-flight: issue 3 back-to-back reads, assert rst_n low 1 cycle after the last acceptance, release -> no resp_valid_o pulses ever; pointers = 0; a new read after release responds normally.
